// File: rtl/pixscan_pkg.sv
// pixscan_pkg
//   Shared definitions for the pixel-scan capture controller: FSM state
//   encodings, Wishbone register addresses, CTRL/STATUS bit positions,
//   the pixel counter width and the COUNT write clamp.
package pixscan_pkg;

    // Pixel counter width; the counter saturates at all-ones.
    localparam int CNT_W       = 24;
    // Wide enough to hold an entry index or a COUNT value of 1..8.
    localparam int IDX_W       = 4;
    localparam int MAX_ENTRIES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word addresses
    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_STATUS = 5'd1;
    localparam logic [4:0] ADDR_COUNT  = 5'd2;
    localparam logic [4:0] ADDR_OFFSET = 5'd8;   // 8..15
    localparam logic [4:0] ADDR_RESULT = 5'd16;  // 16..23

    // CTRL bits (write-only register)
    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_INTEN = 2;

    // STATUS fields
    localparam int STAT_STATE_LSB  = 0;   // [1:0]
    localparam int STAT_IDX_LSB    = 4;   // [6:4]
    localparam int STAT_MISSED_LSB = 8;   // [15:8]
    localparam int STAT_INTEN      = 16;
    localparam int STAT_DONE       = 17;

    // COUNT is always 1..nentries: zero stores 1, oversize stores the max.
    function automatic logic [IDX_W-1:0] clamp_count(input logic [31:0] wdata,
                                                     input int unsigned nentries);
        if (wdata == 32'd0) begin
            return IDX_W'(1);
        end else if (wdata > 32'(nentries)) begin
            return IDX_W'(nentries);
        end else begin
            return wdata[IDX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pixscan_regs.sv
// pixscan_regs
//   OFFSET/RESULT storage and Wishbone readback for pixscan_ctrl.
//   Ports:
//     i_clk, i_reset        clock, asynchronous active-high reset
//     i_wb_cyc/stb/we/addr  bus request (from the top-level ports)
//     i_wb_offset_data      low 24 bits of the write data
//     i_cfg_open            OFFSET writes are accepted only when high
//     i_status, i_count     STATUS word and COUNT value for readback
//     i_idx, o_cur_offset   OFFSET[idx] lookup for the scan compare
//     i_res_mask, i_res_data  RESULT write port (any set of slots, one value)
//     o_wb_ack, o_wb_data   registered acknowledge and read data
//   OFFSET and RESULT are deliberately not reset; only the bus outputs are.
module pixscan_regs
    import pixscan_pkg::*;
#(
    parameter int NENTRIES = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [4:0]          i_wb_addr,
    input  logic [CNT_W-1:0]    i_wb_offset_data,
    input  logic                i_cfg_open,
    input  logic [31:0]         i_status,
    input  logic [IDX_W-1:0]    i_count,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [CNT_W-1:0]    o_cur_offset,
    input  logic [NENTRIES-1:0] i_res_mask,
    input  logic [31:0]         i_res_data,
    output logic                o_wb_ack,
    output logic [31:0]         o_wb_data
);

    logic [CNT_W-1:0] offset_q [NENTRIES];
    logic [31:0]      result_q [NENTRIES];
    logic             offset_wr;
    logic [31:0]      rdata;

    assign offset_wr = i_wb_cyc & i_wb_stb & i_wb_we & i_cfg_open;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NENTRIES; k++) begin
            if (offset_wr && (i_wb_addr == ADDR_OFFSET + 5'(k))) begin
                offset_q[k] <= i_wb_offset_data;
            end
            if (i_res_mask[k]) begin
                result_q[k] <= i_res_data;
            end
        end
    end

    // Entry currently being searched for; slots past NENTRIES read 0
    // but are never compared because idx < COUNT <= NENTRIES in SCAN.
    always_comb begin
        o_cur_offset = '0;
        for (int k = 0; k < NENTRIES; k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_cur_offset = offset_q[k];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (i_wb_addr == ADDR_STATUS) begin
            rdata = i_status;
        end else if (i_wb_addr == ADDR_COUNT) begin
            rdata = 32'(i_count);
        end
        for (int k = 0; k < NENTRIES; k++) begin
            if (i_wb_addr == ADDR_OFFSET + 5'(k)) begin
                rdata = {{(32-CNT_W){1'b0}}, offset_q[k]};
            end
            if (i_wb_addr == ADDR_RESULT + 5'(k)) begin
                rdata = result_q[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= i_wb_stb;
            o_wb_data <= rdata;
        end
    end

endmodule

// File: rtl/pixscan_ctrl.sv
// pixscan_ctrl
//   Captures up to NENTRIES pixels at programmed offsets within a frame.
//   Software writes COUNT and OFFSET[k], sets ARM; on i_frame_start the
//   controller counts valid pixels and stores the pixel whose index equals
//   OFFSET[idx] into RESULT[idx]. An offset already passed is recorded as
//   missed with RESULT 0. A new frame start before all entries resolve
//   misses the remainder.
//   Ports:
//     i_clk, i_reset                     clock, async active-high reset
//     i_wb_cyc/stb/we/addr/data          Wishbone pipelined request
//     o_wb_stall/ack/data                Wishbone response (never stalls)
//     i_frame_start, i_pix_valid, i_data pixel stream
//     o_busy                             FSM is not IDLE
//     o_int                              done & INTEN (level)
//   Bus handshake: a request is taken on every cycle with cyc & stb high;
//   stall is always 0 and ack follows stb exactly one cycle later, with
//   read data registered on the same edge.
module pixscan_ctrl
    import pixscan_pkg::*;
#(
    parameter int NENTRIES = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_frame_start,
    input  logic        i_pix_valid,
    input  logic [31:0] i_data,
    output logic        o_busy,
    output logic        o_int
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     count_q, count_d;
    logic [NENTRIES-1:0]  missed_q, missed_d;
    logic                 done_q, done_d;
    logic                 inten_q, inten_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 bus_wr, bus_rd;
    logic                 ctrl_wr, arm, abort, status_rd, count_wr;
    logic                 cfg_open;
    logic [CNT_W-1:0]     cur_offset;
    logic [CNT_W-1:0]     pix_idx;
    logic                 hit, past, resolve;
    logic [NENTRIES-1:0]  idx_onehot;
    logic [NENTRIES-1:0]  res_mask;
    logic [31:0]          res_data;
    logic [31:0]          status;

    assign bus_wr    = i_wb_cyc & i_wb_stb & i_wb_we;
    assign bus_rd    = i_wb_cyc & i_wb_stb & ~i_wb_we;
    assign ctrl_wr   = bus_wr && (i_wb_addr == ADDR_CTRL);
    assign arm       = ctrl_wr & i_wb_data[CTRL_ARM];
    assign abort     = ctrl_wr & i_wb_data[CTRL_ABORT];
    assign status_rd = bus_rd && (i_wb_addr == ADDR_STATUS);
    assign count_wr  = bus_wr && (i_wb_addr == ADDR_COUNT);
    assign cfg_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // The frame-start pixel in ARMED is index 0; in SCAN the counter
    // already holds the index of the pixel on the bus this cycle.
    assign pix_idx = (state_q == ST_ARMED) ? '0 : cnt_q;
    assign hit     = (pix_idx == cur_offset);
    assign past    = (pix_idx > cur_offset);

    always_comb begin
        idx_onehot = '0;
        for (int k = 0; k < NENTRIES; k++) begin
            idx_onehot[k] = (idx_q == IDX_W'(k));
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        missed_d = missed_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        res_mask = '0;
        res_data = '0;
        resolve  = 1'b0;
        inten_d  = ctrl_wr ? i_wb_data[CTRL_INTEN] : inten_q;
        count_d  = (count_wr && cfg_open) ? clamp_count(i_wb_data, NENTRIES) : count_q;

        // Read-to-clear; a completion on the same edge overrides below.
        if (status_rd) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    idx_d    = '0;
                    missed_d = '0;
                    done_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (i_frame_start) begin
                    state_d = ST_SCAN;
                    cnt_d   = i_pix_valid ? CNT_W'(1) : '0;
                    resolve = i_pix_valid;
                end
            end
            ST_SCAN: begin
                if (idx_q >= count_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (i_frame_start) begin
                    // Frame ended early: every unresolved entry is missed.
                    for (int k = 0; k < NENTRIES; k++) begin
                        if ((IDX_W'(k) >= idx_q) && (IDX_W'(k) < count_q)) begin
                            res_mask[k] = 1'b1;
                            missed_d[k] = 1'b1;
                        end
                    end
                    idx_d   = count_q;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (i_pix_valid) begin
                    resolve = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // One entry per cycle: exact match captures, overshoot misses.
        if (resolve && (hit || past)) begin
            res_mask = idx_onehot;
            res_data = hit ? i_data : '0;
            if (!hit) begin
                missed_d = missed_q | idx_onehot;
            end
            idx_d = idx_q + IDX_W'(1);
        end

        // Abort overrides everything else decided this cycle.
        if (abort) begin
            state_d  = ST_IDLE;
            idx_d    = idx_q;
            missed_d = missed_q;
            res_mask = '0;
            done_d   = status_rd ? 1'b0 : done_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= IDX_W'(1);
            missed_q <= '0;
            done_q   <= 1'b0;
            inten_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            missed_q <= missed_d;
            done_q   <= done_d;
            inten_q  <= inten_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        status = '0;
        status[STAT_STATE_LSB +: 2] = state_q;
        status[STAT_IDX_LSB +: 3]   = idx_q[2:0];
        for (int k = 0; k < NENTRIES; k++) begin
            status[STAT_MISSED_LSB + k] = missed_q[k];
        end
        status[STAT_INTEN] = inten_q;
        status[STAT_DONE]  = done_q;
    end

    assign o_wb_stall = 1'b0;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_int      = done_q & inten_q;

    pixscan_regs #(
        .NENTRIES (NENTRIES)
    ) u_regs (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_wb_cyc         (i_wb_cyc),
        .i_wb_stb         (i_wb_stb),
        .i_wb_we          (i_wb_we),
        .i_wb_addr        (i_wb_addr),
        .i_wb_offset_data (i_wb_data[CNT_W-1:0]),
        .i_cfg_open       (cfg_open),
        .i_status         (status),
        .i_count          (count_q),
        .i_idx            (idx_q),
        .o_cur_offset     (cur_offset),
        .i_res_mask       (res_mask),
        .i_res_data       (res_data),
        .o_wb_ack         (o_wb_ack),
        .o_wb_data        (o_wb_data)
    );

endmodule

// File: tb/tb_pixscan_ctrl.sv
// tb_pixscan_ctrl
//   Bench for pixscan_ctrl: register-map vectors from a table, then
//   hand-written scan sequences. Bus reads push their expected data into
//   a queue; a negedge monitor pops and compares on each o_wb_ack.
module tb_pixscan_ctrl;

    localparam logic [4:0] A_CTRL   = 5'd0;
    localparam logic [4:0] A_STATUS = 5'd1;
    localparam logic [4:0] A_COUNT  = 5'd2;
    localparam logic [4:0] A_OFF    = 5'd8;
    localparam logic [4:0] A_RES    = 5'd16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        i_frame_start, i_pix_valid;
    logic [31:0] i_data;
    logic        o_busy, o_int;

    pixscan_ctrl #(.NENTRIES(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wb_cyc      (i_wb_cyc),
        .i_wb_stb      (i_wb_stb),
        .i_wb_we       (i_wb_we),
        .i_wb_addr     (i_wb_addr),
        .i_wb_data     (i_wb_data),
        .o_wb_stall    (o_wb_stall),
        .o_wb_ack      (o_wb_ack),
        .o_wb_data     (o_wb_data),
        .i_frame_start (i_frame_start),
        .i_pix_valid   (i_pix_valid),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .o_int         (o_int)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          is_rd_q[$];
    bit          mon_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_wb_ack === 1'b1) begin
            if (is_rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack with no request outstanding, expected none");
            end else begin
                mon_rd = is_rd_q.pop_front();
                if (mon_rd) begin
                    check(name_q.pop_front(), o_wb_data, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wb_clear();
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = '0;
        i_wb_data = '0;
    endtask

    task automatic wb_set_write(input logic [4:0] a, input logic [31:0] dat);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b1;
        i_wb_addr = a;
        i_wb_data = dat;
        is_rd_q.push_back(1'b0);
    endtask

    task automatic wb_set_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = a;
        i_wb_data = '0;
        is_rd_q.push_back(1'b1);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] dat);
        wb_set_write(a, dat);
        tick();
        wb_clear();
    endtask

    task automatic wb_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        wb_set_read(a, exp, name);
        tick();
        wb_clear();
    endtask

    task automatic pix(input logic fs, input logic pv, input logic [31:0] dat);
        i_frame_start = fs;
        i_pix_valid   = pv;
        i_data        = dat;
        tick();
        i_frame_start = 1'b0;
        i_pix_valid   = 1'b0;
        i_data        = '0;
    endtask

    // ---------------- register vectors ----------------
    typedef struct {
        logic        do_wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t    vecs [14];
    logic [31:0] d [64];
    logic [31:0] x;

    initial begin
        i_reset = 1'b1;
        wb_clear();
        i_frame_start = 1'b0;
        i_pix_valid   = 1'b0;
        i_data        = '0;
        for (int i = 0; i < 64; i++) begin
            d[i] = 32'($urandom_range(1, 32'h7fff_ffff));
        end
        x = 32'($urandom_range(1, 32'h7fff_ffff));

        vecs[0]  = '{1'b1, A_COUNT,     32'd0,         32'd1};
        vecs[1]  = '{1'b1, A_COUNT,     32'd5,         32'd5};
        vecs[2]  = '{1'b1, A_COUNT,     32'd9,         32'd8};
        vecs[3]  = '{1'b1, A_COUNT,     32'hFFFF_FFFF, 32'd8};
        vecs[4]  = '{1'b1, A_COUNT,     32'd8,         32'd8};
        vecs[5]  = '{1'b1, A_COUNT,     32'd1,         32'd1};
        vecs[6]  = '{1'b1, A_OFF + 5'd3, 32'hABCD_EF12, 32'h00CD_EF12};
        vecs[7]  = '{1'b1, A_OFF + 5'd7, 32'h00FF_FFFF, 32'h00FF_FFFF};
        vecs[8]  = '{1'b0, 5'd3,        32'd0,         32'd0};
        vecs[9]  = '{1'b0, 5'd4,        32'd0,         32'd0};
        vecs[10] = '{1'b0, 5'd24,       32'd0,         32'd0};
        vecs[11] = '{1'b0, 5'd31,       32'd0,         32'd0};
        vecs[12] = '{1'b0, A_CTRL,      32'd0,         32'd0};
        vecs[13] = '{1'b0, A_STATUS,    32'd0,         32'd0};

        // Reset values while reset is held
        #12;
        check("rst_busy",  32'(o_busy),     32'd0);
        check("rst_int",   32'(o_int),      32'd0);
        check("rst_ack",   32'(o_wb_ack),   32'd0);
        check("rst_rdata", o_wb_data,       32'd0);
        check("stall",     32'(o_wb_stall), 32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        wb_read(A_STATUS, 32'd0, "rst_status");
        wb_read(A_COUNT,  32'd1, "rst_count");

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].do_wr) wb_write(vecs[i].addr, vecs[i].wdata);
            wb_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Three ascending offsets, all captured
        wb_write(A_COUNT, 32'd3);
        wb_write(A_OFF + 5'd0, 32'd2);
        wb_write(A_OFF + 5'd1, 32'd5);
        wb_write(A_OFF + 5'd2, 32'd9);
        wb_write(A_CTRL, 32'h1);
        wb_read(A_STATUS, 32'h0000_0001, "s1_armed");
        pix(1'b1, 1'b0, 32'd0);
        check("s1_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i <= 12; i++) pix(1'b0, 1'b1, d[i]);
        wb_read(A_STATUS, 32'h0002_0033, "s1_status");
        wb_read(A_STATUS, 32'h0000_0033, "s1_status_clr");
        wb_read(A_RES + 5'd0, d[2], "s1_res0");
        wb_read(A_RES + 5'd1, d[5], "s1_res1");
        wb_read(A_RES + 5'd2, d[9], "s1_res2");

        // Duplicate offset: second entry misses
        wb_write(A_OFF + 5'd0, 32'd4);
        wb_write(A_OFF + 5'd1, 32'd4);
        wb_write(A_COUNT, 32'd2);
        wb_write(A_CTRL, 32'h1);
        pix(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) pix(1'b0, 1'b1, d[i]);
        wb_read(A_STATUS, 32'h0002_0223, "s2_status");
        wb_read(A_RES + 5'd0, d[4],  "s2_res0");
        wb_read(A_RES + 5'd1, 32'd0, "s2_res1");

        // Early frame start misses the pending entry; config locked while armed
        wb_write(A_COUNT, 32'd1);
        wb_write(A_OFF + 5'd0, 32'd100);
        wb_write(A_CTRL, 32'h1);
        wb_write(A_COUNT, 32'd5);
        wb_write(A_OFF + 5'd0, 32'd7);
        wb_read(A_COUNT, 32'd1, "s3_count_locked");
        wb_read(A_OFF + 5'd0, 32'd100, "s3_off_locked");
        pix(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 50; i++) pix(1'b0, 1'b1, d[i]);
        pix(1'b1, 1'b0, 32'd0);
        wb_read(A_STATUS, 32'h0002_0113, "s3_status");
        wb_read(A_RES + 5'd0, 32'd0, "s3_res0");

        // Frame start and valid together hit offset 0
        wb_write(A_OFF + 5'd0, 32'd0);
        wb_write(A_CTRL, 32'h1);
        pix(1'b1, 1'b1, x);
        tick();
        wb_read(A_STATUS, 32'h0002_0013, "s4_status");
        wb_read(A_RES + 5'd0, x, "s4_res0");

        // Abort on a matching pixel, then interrupt and read-to-clear
        wb_write(A_OFF + 5'd0, 32'd3);
        wb_write(A_CTRL, 32'h5);
        pix(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, d[i]);
        i_pix_valid = 1'b1;
        i_data      = d[3];
        wb_set_write(A_CTRL, 32'h6);
        tick();
        wb_clear();
        i_pix_valid = 1'b0;
        i_data      = '0;
        wb_read(A_STATUS, 32'h0001_0000, "s5_abort_status");
        wb_read(A_RES + 5'd0, x, "s5_abort_res0");
        check("s5_int_idle", 32'(o_int), 32'd0);
        wb_write(A_CTRL, 32'h5);
        pix(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) pix(1'b0, 1'b1, d[i]);
        @(negedge i_clk);
        check("s5_int_set", 32'(o_int), 32'd1);
        wb_read(A_STATUS, 32'h0003_0013, "s5_status");
        @(negedge i_clk);
        check("s5_int_clr", 32'(o_int), 32'd0);
        wb_read(A_RES + 5'd0, d[3], "s5_res0");

        // Reset mid-scan: outputs drop at once, results untouched
        wb_write(A_COUNT, 32'd2);
        wb_write(A_OFF + 5'd0, 32'd10);
        wb_write(A_OFF + 5'd1, 32'd20);
        wb_write(A_CTRL, 32'h1);
        pix(1'b1, 1'b0, 32'd0);
        for (int i = 0; i <= 12; i++) pix(1'b0, 1'b1, d[i]);
        // Untracked read so ack/data are non-zero when reset hits
        i_wb_cyc    = 1'b1;
        i_wb_stb    = 1'b1;
        i_wb_we     = 1'b0;
        i_wb_addr   = A_RES;
        i_pix_valid = 1'b1;
        i_data      = d[13];
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        wb_clear();
        #1;
        check("s6_rst_ack",   32'(o_wb_ack), 32'd0);
        check("s6_rst_rdata", o_wb_data,     32'd0);
        check("s6_rst_busy",  32'(o_busy),   32'd0);
        check("s6_rst_int",   32'(o_int),    32'd0);
        for (int i = 14; i < 26; i++) pix(1'b0, 1'b1, d[i]);
        i_reset = 1'b0;
        for (int i = 26; i < 30; i++) pix(1'b0, 1'b1, d[i]);
        wb_read(A_STATUS, 32'd0, "s6_status");
        wb_read(A_COUNT,  32'd1, "s6_count");
        wb_read(A_OFF + 5'd0, 32'd10, "s6_off0");
        wb_read(A_OFF + 5'd1, 32'd20, "s6_off1");
        wb_read(A_RES + 5'd0, d[10], "s6_res0");
        wb_read(A_RES + 5'd1, 32'd0, "s6_res1");

        // ---------------- report ----------------
        tick();
        tick();
        check("sb_drain_rd",  32'(exp_q.size()),   32'd0);
        check("sb_drain_all", 32'(is_rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
